// File: rtl/vram_port_arbiter_if.sv
// Bundle of video-fetch, Avalon-MM slave and video-RAM signals seen by the arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface vram_port_arbiter_if #(
  parameter int AW    = 13,
  parameter int DW    = 32,
  parameter int BURST = 40
);
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_busy;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic [IW-1:0] vid_ridx;
  logic          vid_done;

  logic          avs_read;
  logic          avs_write;
  logic [AW-1:0] avs_address;
  logic [DW-1:0] avs_writedata;
  logic          avs_waitrequest;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr,
    output vid_busy, vid_rvalid, vid_rdata, vid_ridx, vid_done,
    input  avs_read, avs_write, avs_address, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_busy, vid_rvalid, vid_rdata, vid_ridx, vid_done,
    output avs_read, avs_write, avs_address, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one single-port video RAM between the VGA line-fetch burst engine (priority)
// and the CPU Avalon-MM slave, which is owed one access slot after every burst.
module vram_port_arbiter #(
  parameter int AW    = 13,
  parameter int DW    = 32,
  parameter int BURST = 40
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  vram_port_arbiter_if.slave   bus
);
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, VID, VID_TAIL, CPU} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic          cpu_owed, cpu_owed_nxt;
  logic          grant_vid;
  logic          cpu_req;
  logic [AW-1:0] vid_base;

  logic [AW-1:0] ram_addr_c;
  logic          ram_we_c;
  logic [DW-1:0] ram_wdata_c;
  logic          wait_c;

  logic          vld_p0;
  logic [IW-1:0] ridx_p0;
  logic          cpu_vld_p0;

  assign cpu_req = bus.avs_read | bus.avs_write;

  always_comb begin
    state_nxt    = IDLE;
    cnt_nxt      = cnt;
    cpu_owed_nxt = cpu_owed;
    grant_vid    = 1'b0;
    ram_addr_c   = '0;
    ram_we_c     = 1'b0;
    ram_wdata_c  = '0;
    wait_c       = 1'b1;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
        // An owed CPU slot beats a pending video request; otherwise video first.
        if (cpu_owed && cpu_req) begin
          state_nxt    = CPU;
          cpu_owed_nxt = 1'b0;
        end else if (bus.vid_req) begin
          state_nxt = VID;
          grant_vid = 1'b1;
          cnt_nxt   = '0;
        end else if (cpu_req) begin
          state_nxt    = CPU;
          cpu_owed_nxt = 1'b0;
        end
      end
      VID: begin
        ram_addr_c = vid_base + AW'(cnt);
        if (cnt == IW'(BURST - 1)) begin
          state_nxt = VID_TAIL;
        end else begin
          state_nxt = VID;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      VID_TAIL: begin
        state_nxt    = IDLE;
        cpu_owed_nxt = 1'b1;
      end
      CPU: begin
        state_nxt  = IDLE;
        wait_c     = 1'b0;
        ram_addr_c = bus.avs_address;
        // Read wins when both strobes are set, so the write is suppressed.
        if (bus.avs_write && !bus.avs_read) begin
          ram_we_c    = 1'b1;
          ram_wdata_c = bus.avs_writedata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cpu_owed   <= 1'b0;
      vld_p0     <= 1'b0;
      cpu_vld_p0 <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cpu_owed   <= cpu_owed_nxt;
      vld_p0     <= (state == VID);
      cpu_vld_p0 <= (state == CPU) && bus.avs_read;
    end
  end

  // p0: RAM read data returns one cycle after the address; index follows it.
  always_ff @(posedge clk_clk) begin
    if (grant_vid) vid_base <= bus.vid_addr;
    if (state == VID) ridx_p0 <= cnt;
  end

  assign bus.vid_busy          = (state == VID) || (state == VID_TAIL);
  assign bus.vid_rvalid        = vld_p0;
  assign bus.vid_rdata         = vld_p0 ? bus.ram_rdata : '0;
  assign bus.vid_ridx          = vld_p0 ? ridx_p0 : '0;
  assign bus.vid_done          = vld_p0 && (state == VID_TAIL);

  assign bus.avs_waitrequest   = wait_c;
  assign bus.avs_readdatavalid = cpu_vld_p0;
  assign bus.avs_readdata      = cpu_vld_p0 ? bus.ram_rdata : '0;

  assign bus.ram_addr          = ram_addr_c;
  assign bus.ram_we            = ram_we_c;
  assign bus.ram_wdata         = ram_wdata_c;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed tables and sequences plus random traffic,
// scored against a transaction-level schedule of expected per-cycle outputs.
module tb_vram_port_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int BURST = 40;
  localparam int IW    = $clog2(BURST);
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_port_arbiter_if #(.AW(AW), .DW(DW), .BURST(BURST)) bus ();

  vram_port_arbiter #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  // Single-port RAM, 1-cycle read latency, preloaded with mem[a] = a.
  logic [DW-1:0] mem [DEPTH];
  bit            ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
      ram_ready <= 1'b1;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, required event within bound", nm);
  endtask

  // Reference model: grants become a schedule of expected outputs keyed by cycle.
  typedef struct {
    bit            rv;
    int            idx;
    logic [DW-1:0] data;
    bit            done;
    bit            busy;
    bit            acc;
    bit            we;
    bit            ac;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            rdv;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sched [int];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc     = 0;
  bit            mon_en  = 1'b0;
  int            free_at = 0;
  bit            owed    = 1'b0;

  function automatic exp_t get_e(input int n);
    exp_t e;
    e.rv = 0; e.idx = 0; e.data = '0; e.done = 0; e.busy = 0; e.acc = 0;
    e.we = 0; e.ac = 0; e.addr = '0; e.wdata = '0; e.rdv = 0; e.rdata = '0;
    if (sched.exists(n)) e = sched[n];
    return e;
  endfunction

  task automatic model_vid(input int n);
    exp_t          e;
    logic [AW-1:0] a;
    for (int k = 0; k < BURST; k++) begin
      a = bus.vid_addr + AW'(k);
      e = get_e(n + 1 + k); e.busy = 1; e.ac = 1; e.addr = a; sched[n + 1 + k] = e;
      e = get_e(n + 2 + k); e.busy = 1; e.rv = 1; e.idx = k; e.data = ref_mem[a];
      e.done = (k == BURST - 1); sched[n + 2 + k] = e;
    end
    free_at = n + BURST + 2;
    owed    = 1'b1;
  endtask

  task automatic model_cpu(input int n);
    exp_t e;
    bit   rd, wr;
    rd = bus.avs_read;
    wr = bus.avs_write && !bus.avs_read;
    e = get_e(n + 1); e.acc = 1; e.ac = 1; e.addr = bus.avs_address; e.we = wr;
    e.wdata = bus.avs_writedata; sched[n + 1] = e;
    if (wr) ref_mem[bus.avs_address] = bus.avs_writedata;
    if (rd) begin
      e = get_e(n + 2); e.rdv = 1; e.rdata = ref_mem[bus.avs_address]; sched[n + 2] = e;
    end
    free_at = n + 2;
    owed    = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic creq;
    if (mon_en) begin
      e = get_e(cyc);
      chk($sformatf("cyc%0d ctrl{rv,done,busy,wait,rdv,we}", cyc),
          {bus.vid_rvalid, bus.vid_done, bus.vid_busy, bus.avs_waitrequest,
           bus.avs_readdatavalid, bus.ram_we},
          {e.rv, e.done, e.busy, !e.acc, e.rdv, e.we});
      if (e.rv) begin
        chk($sformatf("cyc%0d vid_ridx", cyc), bus.vid_ridx, e.idx);
        chk($sformatf("cyc%0d vid_rdata", cyc), bus.vid_rdata, e.data);
      end
      if (e.ac) chk($sformatf("cyc%0d ram_addr", cyc), bus.ram_addr, e.addr);
      if (e.we) chk($sformatf("cyc%0d ram_wdata", cyc), bus.ram_wdata, e.wdata);
      if (e.rdv) chk($sformatf("cyc%0d avs_readdata", cyc), bus.avs_readdata, e.rdata);
      sched.delete(cyc);
      creq = bus.avs_read | bus.avs_write;
      if (rst) begin
        sched.delete();
        free_at = cyc + 1;
        owed    = 1'b0;
      end else if (cyc >= free_at) begin
        if (owed && creq)      model_cpu(cyc);
        else if (bus.vid_req)  model_vid(cyc);
        else if (creq)         model_cpu(cyc);
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers (all start and end at a drive point) -------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rdata,
                        output int waits);
    bit acc = 1'b0;
    waits = 0;
    rdata = '0;
    bus.avs_read = rd; bus.avs_write = wr; bus.avs_address = a; bus.avs_writedata = wd;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (!bus.avs_waitrequest) acc = 1'b1;
      else waits++;
    end
    if (!acc) fail("cpu accept");
    tick();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    if (rd && acc) begin
      @(negedge clk);
      chk("avs_readdatavalid after accept", bus.avs_readdatavalid, 1);
      rdata = bus.avs_readdata;
      tick();
    end
  endtask

  task automatic vid_burst(input logic [AW-1:0] a, input logic [DW-1:0] d_first,
                           input logic [DW-1:0] d_last, input string nm);
    int            lat = -1, beats = 0, last_idx = -1;
    bit            done = 1'b0, order_ok = 1'b1;
    logic [DW-1:0] first_d = '0, last_d = '0;
    bus.vid_req = 1'b1; bus.vid_addr = a;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.vid_rvalid) begin
        if (lat < 0) begin lat = i; first_d = bus.vid_rdata; end
        if (int'(bus.vid_ridx) != beats) order_ok = 1'b0;
        beats++;
        if (bus.vid_done) begin done = 1'b1; last_idx = int'(bus.vid_ridx); last_d = bus.vid_rdata; end
      end
      tick();
      if (i == 0) bus.vid_req = 1'b0;
    end
    if (!done) fail({nm, " vid_done"});
    chk({nm, " first beat latency"}, lat, 2);
    chk({nm, " beat count"}, beats, BURST);
    chk({nm, " ridx in order"}, order_ok, 1);
    chk({nm, " done ridx"}, last_idx, BURST - 1);
    chk({nm, " first data"}, first_d, d_first);
    chk({nm, " last data"}, last_d, d_last);
  endtask

  task automatic wait_idle(input string nm);
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(negedge clk);
      if (!bus.vid_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) fail({nm, " idle"});
    tick();
  endtask

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
    int            exp_waits;
    string         nm;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [7];
    logic [DW-1:0] rdat;
    int            w, seen;
    bit            pend, drop;
    int            r;

    tbl[0] = '{1'b0, 1'b1, 13'h0020, 32'hDEADBEEF, 32'h0,        1, "wr 0x20"};
    tbl[1] = '{1'b1, 1'b0, 13'h0020, 32'h0,        32'hDEADBEEF, 1, "rd 0x20"};
    tbl[2] = '{1'b1, 1'b0, 13'h0035, 32'h0,        32'h00000035, 1, "rd 0x35"};
    tbl[3] = '{1'b1, 1'b1, 13'h0040, 32'h12345678, 32'h00000040, 1, "rd+wr 0x40"};
    tbl[4] = '{1'b1, 1'b0, 13'h0040, 32'h0,        32'h00000040, 1, "rd 0x40 after rd+wr"};
    tbl[5] = '{1'b0, 1'b1, 13'h1FFF, 32'hA5A5A5A5, 32'h0,        1, "wr 0x1FFF"};
    tbl[6] = '{1'b1, 1'b0, 13'h1FFF, 32'h0,        32'hA5A5A5A5, 1, "rd 0x1FFF"};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.avs_read = 0; bus.avs_write = 0; bus.avs_address = '0; bus.avs_writedata = '0;
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    chk("reset vid_rdata", bus.vid_rdata, 0);
    chk("reset vid_ridx", bus.vid_ridx, 0);
    chk("reset avs_readdata", bus.avs_readdata, 0);
    chk("reset ram_addr", bus.ram_addr, 0);
    chk("reset ram_wdata", bus.ram_wdata, 0);
    chk("reset avs_waitrequest", bus.avs_waitrequest, 1);
    tick();
    rst = 1'b0;
    tick();

    // CPU accesses with no video traffic.
    for (int i = 0; i < 7; i++) begin
      cpu_op(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, rdat, w);
      chk({tbl[i].nm, " waits"}, w, tbl[i].exp_waits);
      if (tbl[i].rd) chk({tbl[i].nm, " rdata"}, rdat, tbl[i].exp_rd);
    end

    // Plain burst, then a burst whose addresses wrap past the top of RAM.
    vid_burst(13'h0100, 32'h100, 32'h127, "burst 0x100");
    vid_burst(13'h1FF0, 32'h1FF0, 32'h17, "burst wrap");

    // vid_req held, CPU read arrives mid-burst: owed slot, then the next burst.
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0300;
    repeat (6) tick();
    cpu_op(1'b1, 1'b0, 13'h0020, '0, rdat, w);
    chk("mid-burst read waits", w, BURST - 3);
    chk("mid-burst read data", rdat, 32'hDEADBEEF);
    @(negedge clk);
    chk("next burst after cpu slot busy", bus.vid_busy, 1);
    tick();
    bus.vid_req = 1'b0;
    wait_idle("after held vid_req");

    // Simultaneous requests with the CPU owed a slot: CPU first.
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0500;
    fork
      cpu_op(1'b1, 1'b0, 13'h0035, '0, rdat, w);
      begin tick(); bus.vid_req = 1'b0; end
    join
    chk("owed cpu beats video waits", w, 1);
    chk("owed cpu beats video data", rdat, 32'h35);
    wait_idle("owed case");

    // Simultaneous requests with nothing owed: video first.
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0600;
    fork
      cpu_op(1'b1, 1'b0, 13'h0020, '0, rdat, w);
      begin tick(); bus.vid_req = 1'b0; end
    join
    chk("video beats cpu waits", w, BURST + 3);
    chk("video beats cpu data", rdat, 32'hDEADBEEF);
    wait_idle("video-wins case");

    // Reset during burst word 10 aborts it; a fresh request runs a full burst.
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0400;
    tick();
    bus.vid_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset vid_rvalid", bus.vid_rvalid, 0);
    chk("post-reset vid_busy", bus.vid_busy, 0);
    chk("post-reset avs_waitrequest", bus.avs_waitrequest, 1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.vid_done || bus.vid_rvalid) seen++;
    end
    chk("aborted burst silent", seen, 0);
    tick();
    vid_burst(13'h0400, 32'h400, 32'h427, "burst after reset");

    // Random traffic.
    pend = 1'b0; drop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pend && !bus.avs_waitrequest) drop = 1'b1;
      tick();
      if (drop) begin bus.avs_read = 0; bus.avs_write = 0; pend = 0; drop = 0; end
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) bus.vid_req = ~bus.vid_req;
      bus.vid_addr = ($urandom_range(0, 3) == 0) ? AW'(13'h1FE0 + $urandom_range(0, 31))
                                                 : AW'($urandom);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        r = $urandom_range(0, 9);
        bus.avs_read      = (r < 5) || (r == 9);
        bus.avs_write     = (r >= 5);
        bus.avs_address   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
        bus.avs_writedata = $urandom;
      end
    end
    @(negedge clk);
    tick();
    bus.avs_read = 0; bus.avs_write = 0; rst = 1'b0; bus.vid_req = 1'b0;
    wait_idle("end of random");
    repeat (4) tick();
    chk("no outstanding expected events", sched.num(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
